decoder_scan_n: RTL
===================

// Module: decoder_scan_n
// PURPOSE
//  - Parametrised, registered N-to-2^N one-hot decoder with enable.
//  - Adds three run-time modes:
//    - DIRECT: registered decode of in.
//    - SCAN: self-timed channel sweep, e.g. for LED/row multiplexing.
//    - PULSE: timed one-hot strobe started by a load.
//  - Sits between control logic and per-channel select lines.
//  - Drives one-hot selects for display, mux and chip-select fan-out.
// PARAMETERS
//  IN_W       2   select width; OUT_W = 1<<IN_W (localparam, not overridable)
//  DWELL      4   cycles per channel in SCAN; strobe length in PULSE; legal range 1..255
//  ACTIVE_LOW 0   1 = inactive level is all-ones and the selected bit is 0 (out inverted)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      synchronous, active-low reset
//  en     in   1      global enable; 0 forces out inactive and freezes state
//  mode   in   2      00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved (idle)
//  in     in   IN_W   channel select (DIRECT / PULSE)
//  load   in   1      PULSE start strobe, sampled with in
//  out    out  OUT_W  registered one-hot (polarity per ACTIVE_LOW)
//  idx    out  IN_W   channel currently driven (0 when idle)
//  wrap   out  1      1-cycle pulse when SCAN returns from last channel to 0
//  busy   out  1      1 while a PULSE strobe is in progress
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - out inactive, idx=0, wrap=0, busy=0, dwell counter=0.
//   - Reset overrides all other inputs, including mid-pulse and mid-scan.
//  All outputs are registered; there is no combinational input-to-output path.
//  en=0:
//   - out inactive, wrap=0.
//   - idx, dwell counter and busy hold; the operation resumes where it stopped once en=1.
//  DIRECT:
//   - out = onehot(in), with 1-cycle latency; idx = in (registered).
//  SCAN:
//   - Entering SCAN (mode change, or reset release while in SCAN): idx=0, and the first
//     out=onehot(0) appears the next cycle.
//   - Each channel is held exactly DWELL enabled cycles, then idx advances by 1.
//   - Channel 2^IN_W-1 is followed by channel 0. wrap=1 in the same cycle out first shows
//     channel 0 after the wrap. The initial entry does not pulse wrap.
//  PULSE:
//   - When load=1, busy=0 and en=1: latch in. The next cycle has out=onehot(in), busy=1.
//   - The strobe holds for exactly DWELL enabled cycles. Then out goes inactive, busy=0.
//   - load while busy=1 is ignored; in changes while busy are ignored.
//   - load in the same cycle busy falls is ignored; a new pulse needs busy=0 at the sample edge.
//  mode 11: out inactive, idx=0, busy=0.
//  Mode change (any transition):
//   - Takes effect at the next edge: dwell counter=0, idx=0.
//   - Any active pulse is aborted (busy=0); wrap=0.
//  Widths:
//   - Dwell counter is 8 bits; it compares against DWELL-1.
//   - idx wrap is natural IN_W overflow.
// STRUCTURE
//  - Shared header decoder_defs.vh:
//    - MODE_DIRECT / MODE_SCAN / MODE_PULSE / MODE_IDLE localparams.
//    - The onehot width macro.
//  - Sub-module decoder_onehot:
//    - Combinational IN_W -> 2^IN_W one-hot decoder with en; generic successor of the
//      2-to-4 decoder.
//    - Instantiated once, feeding the output register.
//  - Top contains the mode/dwell/idx control and the output register (~150-250 lines).
// TESTING (IN_W=2, DWELL=3, ACTIVE_LOW=0 unless stated)
//  1. Reset/DIRECT:
//     - rst_n=0 two cycles: out=0000, idx=0, busy=0, wrap=0.
//     - Then en=1, mode=00, in=0,1,2,3 on successive cycles: out=0001,0010,0100,1000,
//       each one cycle late.
//  2. SCAN wrap:
//     - Run mode=01 for 14 cycles: out sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, then 0001.
//     - wrap=1 only on that 13th output cycle.
//  3. PULSE:
//     - load=1, in=2'b10: out=0100, busy=1 for exactly 3 cycles, then 0000 and busy=0.
//     - A second load at pulse cycle 2 has no effect.
//  4. en gating:
//     - In SCAN at the 2nd cycle of channel 1, en=0 for 5 cycles: out=0000, idx stays 1.
//     - On en=1, channel 1 finishes its remaining 2 cycles.
//  5. Mode change / reset mid-op:
//     - Switching PULSE->DIRECT mid-strobe aborts it next cycle (busy=0, out=onehot(in)).
//     - rst_n=0 mid-SCAN gives out=0000, idx=0 at the next edge.
//  6. ACTIVE_LOW=1, IN_W=3:
//     - DIRECT in=5: out=8'b1101_1111. Reset/en=0: out=8'hFF.

Source files
------------

// File: rtl/decoder_scan_n_pkg.sv
// Shared definitions for the one-hot select decoder: run-time modes,
// dwell counter width and the decoded output width.
package decoder_scan_n_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_PULSE  = 2'b10,
      MODE_IDLE   = 2'b11
   } mode_e;

   localparam int CNT_W = 8;

   function automatic int onehot_w(input int in_w);
      return 1 << in_w;
   endfunction

endpackage

// File: rtl/decoder_scan_n_onehot.sv
// Combinational IN_W -> 2^IN_W one-hot decoder with enable (active-high bits).
module decoder_scan_n_onehot
   import decoder_scan_n_pkg::*;
#(
   parameter int IN_W = 2
) (
   input  logic                         en,
   input  logic [IN_W-1:0]              sel,
   output logic [onehot_w(IN_W)-1:0]    dec
);

   always_comb begin
      dec = '0;
      if (en) dec[sel] = 1'b1;
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot select decoder with DIRECT, self-timed SCAN and timed
// PULSE modes; all outputs come straight from flops.
module decoder_scan_n
   import decoder_scan_n_pkg::*;
#(
   parameter int IN_W       = 2,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic [IN_W-1:0]              in,
   input  logic                         load,
   output logic [onehot_w(IN_W)-1:0]    out,
   output logic [IN_W-1:0]              idx,
   output logic                         wrap,
   output logic                         busy
);

   localparam int               OUT_W      = onehot_w(IN_W);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [OUT_W-1:0] INACTIVE   = ACTIVE_LOW ? '1 : '0;

   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [IN_W-1:0]  idx_d, sel_d;
   logic             busy_d, wrap_d, drive_d;
   logic [OUT_W-1:0] dec;

   // mode_q only tracks mode while enabled, so a change made during en=0
   // is applied on the first enabled edge.
   always_comb begin
      mode_d  = mode_q;
      cnt_d   = cnt;
      idx_d   = idx;
      busy_d  = busy;
      wrap_d  = 1'b0;
      drive_d = 1'b0;
      sel_d   = idx;
      if (en) begin
         mode_d = mode;
         if (mode != mode_q) begin
            cnt_d  = '0;
            idx_d  = '0;
            busy_d = 1'b0;
            if (mode == MODE_DIRECT) begin
               idx_d   = in;
               sel_d   = in;
               drive_d = 1'b1;
            end else if (mode == MODE_SCAN) begin
               sel_d   = '0;
               drive_d = 1'b1;
            end
         end else begin
            case (mode)
               MODE_DIRECT: begin
                  idx_d   = in;
                  sel_d   = in;
                  drive_d = 1'b1;
               end
               MODE_SCAN: begin
                  if (cnt == DWELL_LAST) begin
                     cnt_d  = '0;
                     idx_d  = idx + 1'b1;
                     wrap_d = (idx == '1);
                  end else begin
                     cnt_d = cnt + 1'b1;
                  end
                  sel_d   = idx_d;
                  drive_d = 1'b1;
               end
               MODE_PULSE: begin
                  // busy is the registered value, so a load on the falling edge is ignored
                  if (busy) begin
                     if (cnt == DWELL_LAST) begin
                        busy_d = 1'b0;
                        cnt_d  = '0;
                        idx_d  = '0;
                     end else begin
                        cnt_d   = cnt + 1'b1;
                        drive_d = 1'b1;
                     end
                  end else if (load) begin
                     busy_d  = 1'b1;
                     cnt_d   = '0;
                     idx_d   = in;
                     sel_d   = in;
                     drive_d = 1'b1;
                  end else begin
                     idx_d = '0;
                  end
               end
               default: begin
                  cnt_d  = '0;
                  idx_d  = '0;
                  busy_d = 1'b0;
               end
            endcase
         end
      end
   end

   decoder_scan_n_onehot #(.IN_W(IN_W)) u_onehot (
      .en  (drive_d),
      .sel (sel_d),
      .dec (dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= MODE_IDLE;
         cnt    <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         wrap   <= 1'b0;
         out    <= INACTIVE;
      end else begin
         mode_q <= mode_d;
         cnt    <= cnt_d;
         idx    <= idx_d;
         busy   <= busy_d;
         wrap   <= wrap_d;
         out    <= dec ^ {OUT_W{ACTIVE_LOW}};
      end
   end

endmodule
